// File: rtl/scarf_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : scarf_byte_master
//  Purpose  : On-chip SCARF transaction initiator. Takes one command at a
//             time and replays it on the byte-level slave bus. It sends three
//             address bytes and then the data bytes. Consecutive strobes are
//             separated by BYTE_GAP idle clocks. Write data streams in on
//             wr_*. Read data streams out on rd_*.
//  Ports    : clk, rst_n_sync        - clock, async active-low reset
//             cmd_*                  - command handshake (slave, dir, addr, len)
//             wr_data/valid/ready    - write byte stream (consumed on wr_ready)
//             rd_data/valid          - read byte stream (no backpressure)
//             busy, done, nack       - status (nack sticky until next accept)
//             read_data_out          - combined slave read bus
//             data_in*, slave_id,rnw - byte-level slave bus
//  Revision : 1.0 - initial release
// ============================================================================
module scarf_byte_master #(
    parameter int         BYTE_GAP      = 4,     // minimum 2
    parameter logic [6:0] IDLE_SLAVE_ID = 7'h00
) (
    input  logic        clk,
    input  logic        rst_n_sync,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_slave_id,
    input  logic        cmd_rnw,
    input  logic [18:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        nack,
    input  logic [7:0]  read_data_out,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    output logic        data_in_finished,
    output logic [6:0]  slave_id,
    output logic        rnw
);

    localparam int               GAP_W    = $clog2(BYTE_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(BYTE_GAP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [1:0]        idx_q, idx_d;      // bytes sent so far, saturates at 3
    logic [18:0]       addr_q, addr_d;
    logic [15:0]       len_q, len_d;      // remaining data bytes
    logic [6:0]        sid_q, sid_d;
    logic              rnw_q, rnw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              nack_q, nack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              fire;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            idx_q      <= 2'd0;
            addr_q     <= 19'd0;
            len_q      <= 16'd0;
            sid_q      <= IDLE_SLAVE_ID;
            rnw_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sid_q      <= sid_d;
            rnw_q      <= rnw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        gap_d            = gap_q;
        idx_d            = idx_q;
        addr_d           = addr_q;
        len_d            = len_q;
        sid_d            = sid_q;
        rnw_d            = rnw_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        nack_d           = nack_q;
        rd_valid_d       = 1'b0;
        rd_data_d        = rd_data_q;
        cmd_ready        = 1'b0;
        wr_ready         = 1'b0;
        data_in          = 8'h00;
        data_in_valid    = 1'b0;
        data_in_finished = 1'b0;
        fire             = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sid_d   = cmd_slave_id;
                    rnw_d   = cmd_rnw;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 2'd0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (idx_q == 2'd3) ? S_DATA : S_ADDR;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            S_ADDR: begin
                data_in_valid = 1'b1;
                case (idx_q)
                    2'd0:    data_in = {5'b00000, addr_q[18:16]};
                    2'd1:    data_in = addr_q[15:8];
                    default: data_in = addr_q[7:0];
                endcase
                idx_d = idx_q + 2'd1;
                gap_d = '0;
                // The addressed slave answers the first address byte with its
                // own ID; anything else means nobody owns that ID.
                if ((idx_q == 2'd0) && (read_data_out != {1'b0, sid_q})) begin
                    nack_d  = 1'b1;
                    state_d = S_FINISH;
                end else if ((idx_q == 2'd2) && (len_q == 16'd0)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_GAP;
                end
            end

            S_DATA: begin
                if (rnw_q) begin
                    // Sample happens with the strobe, before the slave
                    // advances its address.
                    fire       = 1'b1;
                    rd_data_d  = read_data_out;
                    rd_valid_d = 1'b1;
                end else if (wr_valid) begin
                    fire     = 1'b1;
                    wr_ready = 1'b1;
                    data_in  = wr_data;
                end
                data_in_valid = fire;
                if (fire) begin
                    len_d   = len_q - 16'd1;
                    gap_d   = '0;
                    state_d = (len_q == 16'd1) ? S_FINISH : S_GAP;
                end
            end

            S_FINISH: begin
                if (gap_q == GAP_FULL) begin
                    data_in_finished = 1'b1;
                    sid_d            = IDLE_SLAVE_ID;
                    rnw_d            = 1'b0;
                    busy_d           = 1'b0;
                    done_d           = 1'b1;
                    gap_d            = '0;
                    state_d          = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack     = nack_q;
    assign slave_id = sid_q;
    assign rnw      = rnw_q;

endmodule
`default_nettype wire

// File: tb/tb_scarf_byte_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scarf_byte_master
//  Purpose  : Self-checking bench for scarf_byte_master with an SRAM-like
//             SCARF slave model, a reference memory and a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scarf_byte_master;

    localparam int         BYTE_GAP = 4;
    localparam logic [6:0] IDLE_ID  = 7'h00;
    localparam logic [6:0] SRAM_ID  = 7'h02;
    localparam logic [6:0] BAD_ID   = 7'h05;

    logic        clk = 1'b0;
    logic        rst_n_sync = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_slave_id = 7'h00;
    logic        cmd_rnw = 1'b0;
    logic [18:0] cmd_addr = 19'h0;
    logic [15:0] cmd_len = 16'h0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy, done, nack;
    logic [7:0]  read_data_out = 8'h00;
    logic [7:0]  data_in;
    logic        data_in_valid, data_in_finished;
    logic [6:0]  slave_id;
    logic        rnw;

    always #5 clk = ~clk;

    scarf_byte_master #(.BYTE_GAP(BYTE_GAP), .IDLE_SLAVE_ID(IDLE_ID)) dut (
        .clk(clk), .rst_n_sync(rst_n_sync),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave_id(cmd_slave_id),
        .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .nack(nack),
        .read_data_out(read_data_out), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_finished(data_in_finished),
        .slave_id(slave_id), .rnw(rnw)
    );

    // ------------------------------------------------------------------ state
    typedef struct packed { logic [7:0] b; logic wd; logic rd; } strb_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    strb_t       exp_strb[$];
    logic [7:0]  exp_rd[$];
    logic        exp_nack[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  wd_fixed[$];
    logic [7:0]  ref_mem[int];
    logic [7:0]  smem[int];
    logic [6:0]  cur_sid = 7'h00;
    logic        cur_rnw = 1'b0;
    int          done_cnt = 0;
    int          done_target = 0;
    int          rd_cnt = 0;
    int          last_strobe = -100;
    int          last_rd_strobe = -100;
    int          fin_cyc = -100;
    int          wr_stall_rem = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [18:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    function automatic logic [7:0] smem_rd(input logic [18:0] a);
        if (smem.exists(int'(a))) return smem[int'(a)];
        return 8'h00;
    endfunction

    // ------------------------------------------------ SRAM-like slave model
    int          s_cnt = 0;
    logic [18:0] s_addr = 19'h0;

    always @(posedge clk) begin
        if (!rst_n_sync || slave_id != SRAM_ID || data_in_finished) begin
            s_cnt = 0;
        end else if (data_in_valid) begin
            case (s_cnt)
                0: s_addr[18:16] = data_in[2:0];
                1: s_addr[15:8]  = data_in;
                2: s_addr[7:0]   = data_in;
                default: begin
                    if (!rnw) smem[int'(s_addr)] = data_in;
                    s_addr = s_addr + 19'd1;
                end
            endcase
            s_cnt++;
        end
        #1;
        if (slave_id != SRAM_ID)  read_data_out = 8'h00;
        else if (s_cnt == 0)      read_data_out = {1'b0, SRAM_ID};
        else if (s_cnt >= 3)      read_data_out = smem_rd(s_addr);
        else                      read_data_out = 8'h00;
    end

    // ------------------------------------------------------ write feeder
    initial begin : p_feed
        bit consumed;
        int stall;
        stall = 0;
        forever begin
            @(negedge clk);
            consumed = wr_valid && wr_ready;
            @(posedge clk);
            #1;
            if (consumed && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                if (wr_q.size() == wr_stall_rem) stall = 20;
            end
            if (stall > 0) begin
                stall--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'h00;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (rst_n_sync) begin
            if (data_in_valid && data_in_finished) check("strobe_and_finish_overlap", 1, 0);
            if (data_in_valid) begin
                if (exp_strb.size() == 0) begin
                    check("extra_strobe", {24'h0, data_in}, 32'h100);
                end else begin
                    strb_t e;
                    e = exp_strb.pop_front();
                    check("data_in", {24'h0, data_in}, {24'h0, e.b});
                    check("strobe_slave_id", {25'h0, slave_id}, {25'h0, cur_sid});
                    check("strobe_rnw", {31'h0, rnw}, {31'h0, cur_rnw});
                    if (e.wd) begin
                        check("wr_ready_with_strobe", {31'h0, wr_ready}, 1);
                        check("write_spacing_min", {31'h0, (cyc - last_strobe) >= BYTE_GAP + 1}, 1);
                    end else begin
                        check("strobe_spacing", cyc - last_strobe, BYTE_GAP + 1);
                    end
                    if (e.rd) last_rd_strobe = cyc;
                end
                last_strobe = cyc;
            end
            if (rd_valid) begin
                check("rd_valid_latency", cyc - last_rd_strobe, 1);
                if (exp_rd.size() == 0) check("extra_rd_valid", {24'h0, rd_data}, 32'h100);
                else check("rd_data", {24'h0, rd_data}, {24'h0, exp_rd.pop_front()});
                rd_cnt++;
            end
            if (data_in_finished) begin
                check("finish_spacing", cyc - last_strobe, BYTE_GAP + 1);
                check("strobes_left_at_finish", exp_strb.size(), 0);
                fin_cyc = cyc;
            end
            if (done) begin
                check("done_after_finish", cyc - fin_cyc, 1);
                check("busy_at_done", {31'h0, busy}, 0);
                check("slave_id_at_done", {25'h0, slave_id}, {25'h0, IDLE_ID});
                check("rnw_at_done", {31'h0, rnw}, 0);
                if (exp_nack.size() == 0) check("extra_done", 1, 0);
                else check("nack_at_done", {31'h0, nack}, {31'h0, exp_nack.pop_front()});
                done_cnt++;
            end
        end
    end

    // ------------------------------------------------------------- tasks
    task automatic check_reset_values(input string tag);
        check({tag, "_data_in"},   {24'h0, data_in}, 0);
        check({tag, "_div"},       {31'h0, data_in_valid}, 0);
        check({tag, "_dif"},       {31'h0, data_in_finished}, 0);
        check({tag, "_slave_id"},  {25'h0, slave_id}, {25'h0, IDLE_ID});
        check({tag, "_rnw"},       {31'h0, rnw}, 0);
        check({tag, "_rd_data"},   {24'h0, rd_data}, 0);
        check({tag, "_rd_valid"},  {31'h0, rd_valid}, 0);
        check({tag, "_wr_ready"},  {31'h0, wr_ready}, 0);
        check({tag, "_busy"},      {31'h0, busy}, 0);
        check({tag, "_done"},      {31'h0, done}, 0);
        check({tag, "_nack"},      {31'h0, nack}, 0);
        check({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 1);
    endtask

    // Builds the expected bus traffic from the command alone, then issues it.
    task automatic issue(input logic [6:0] sid, input logic r, input logic [18:0] a,
                         input logic [15:0] len, input int stall_rem, input bit poke);
        bit    ok;
        strb_t s;
        ok = (sid == SRAM_ID);
        s.wd = 1'b0; s.rd = 1'b0;
        s.b = {5'b00000, a[18:16]}; exp_strb.push_back(s);
        if (ok) begin
            s.b = a[15:8]; exp_strb.push_back(s);
            s.b = a[7:0];  exp_strb.push_back(s);
            for (int i = 0; i < int'(len); i++) begin
                logic [18:0] ai;
                logic [7:0]  d;
                ai = a + 19'(i);
                if (r) begin
                    s.b = 8'h00; s.wd = 1'b0; s.rd = 1'b1;
                    exp_rd.push_back(ref_rd(ai));
                end else begin
                    if (wd_fixed.size() > 0) d = wd_fixed.pop_front();
                    else d = 8'($urandom);
                    s.b = d; s.wd = 1'b1; s.rd = 1'b0;
                    wr_q.push_back(d);
                    ref_mem[int'(ai)] = d;
                end
                exp_strb.push_back(s);
            end
        end
        exp_nack.push_back(!ok);
        done_target++;
        wr_stall_rem = stall_rem;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_slave_id = sid; cmd_rnw = r; cmd_addr = a; cmd_len = len;
        @(negedge clk);
        check("cmd_ready_idle", {31'h0, cmd_ready}, 1);
        cur_sid = sid; cur_rnw = r; last_strobe = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_slave_id = 7'($urandom); cmd_rnw = 1'($urandom);
        cmd_addr = 19'($urandom); cmd_len = 16'($urandom);
        @(negedge clk);
        check("busy_after_accept", {31'h0, busy}, 1);
        check("nack_cleared_on_accept", {31'h0, nack}, 0);
        check("cmd_ready_while_busy", {31'h0, cmd_ready}, 0);
        check("slave_id_after_accept", {25'h0, slave_id}, {25'h0, sid});
        check("rnw_after_accept", {31'h0, rnw}, {31'h0, r});
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            cmd_valid = 1'b1; cmd_slave_id = SRAM_ID; cmd_rnw = 1'b0; cmd_len = 16'd5;
            repeat (5) begin
                @(negedge clk);
                check("cmd_ready_ignored_busy", {31'h0, cmd_ready}, 0);
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (done_cnt < done_target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("done_within_budget", done_cnt, done_target);
        @(negedge clk);
    endtask

    task automatic run(input logic [6:0] sid, input logic r, input logic [18:0] a,
                       input logic [15:0] len, input int stall_rem, input bit poke);
        issue(sid, r, a, len, stall_rem, poke);
        wait_done((int'(len) + 4) * (BYTE_GAP + 1) + 60);
        if (!r && sid == SRAM_ID)
            for (int i = 0; i < int'(len); i++)
                check("sram_contents", {24'h0, smem_rd(a + 19'(i))}, {24'h0, ref_rd(a + 19'(i))});
    endtask

    task automatic preload(input logic [18:0] a, input logic [7:0] d);
        smem[int'(a)]    = d;
        ref_mem[int'(a)] = d;
    endtask

    // --------------------------------------------------------------- main
    initial begin : p_main
        int t;
        int rd0;
        #1;
        check_reset_values("reset");
        repeat (3) @(posedge clk);
        #1 rst_n_sync = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        // Fixed write A1 B2 C3
        wd_fixed = '{8'hA1, 8'hB2, 8'hC3};
        run(SRAM_ID, 1'b0, 19'h12345, 16'd3, -1, 1'b0);
        check("sram_12345", {24'h0, smem_rd(19'h12345)}, 32'hA1);
        check("sram_12346", {24'h0, smem_rd(19'h12346)}, 32'hB2);
        check("sram_12347", {24'h0, smem_rd(19'h12347)}, 32'hC3);
        check("nack_after_write", {31'h0, nack}, 0);

        // Fixed read 10 11 12 13
        for (int i = 0; i < 4; i++) preload(19'h00010 + 19'(i), 8'h10 + 8'(i));
        rd0 = rd_cnt;
        run(SRAM_ID, 1'b1, 19'h00010, 16'd4, -1, 1'b0);
        check("read_count", rd_cnt - rd0, 4);

        // Wrong ID
        run(BAD_ID, 1'b1, 19'h00ABC, 16'd2, -1, 1'b0);
        check("nack_sticky", {31'h0, nack}, 1);

        // Write stall before 2nd data byte (next accept also clears nack)
        run(SRAM_ID, 1'b0, 19'h00200, 16'd3, 2, 1'b0);

        // Zero-length with commands offered while busy
        run(SRAM_ID, 1'b0, 19'h54321, 16'd0, -1, 1'b1);

        // Reset in the middle of a read data phase
        for (int i = 0; i < 8; i++) preload(19'h00100 + 19'(i), 8'($urandom));
        rd0 = rd_cnt;
        issue(SRAM_ID, 1'b1, 19'h00100, 16'd8, -1, 1'b0);
        t = 0;
        while (rd_cnt - rd0 < 2 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("reached_read_data", {31'h0, (rd_cnt - rd0) >= 2}, 1);
        @(negedge clk);
        #2 rst_n_sync = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_strb.delete(); exp_rd.delete(); exp_nack.delete(); wr_q.delete();
        done_target = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n_sync = 1'b1;
        run(SRAM_ID, 1'b1, 19'h00100, 16'd3, -1, 1'b0);

        // Randomized commands
        for (int n = 0; n < 12; n++) begin
            logic [6:0]  sid;
            logic        r;
            logic [18:0] a;
            logic [15:0] len;
            int          st;
            sid = ($urandom_range(0, 4) == 0) ? BAD_ID : SRAM_ID;
            r   = 1'($urandom);
            a   = (($urandom_range(0, 1) == 0) ? 19'h20000 : 19'h7FFC0) + 19'($urandom_range(0, 63));
            len = 16'($urandom_range(0, 6));
            st  = (!r && len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, int'(len) - 1) : -1;
            run(sid, r, a, len, st, 1'b0);
        end

        repeat (10) @(posedge clk);
        check("no_pending_strobes", exp_strb.size(), 0);
        check("no_pending_reads", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/scarf_byte_master.md
Name: scarf_byte_master

Overview:
- On-chip SCARF transaction initiator. Drives the same byte-level slave bus that the SPI decoder drives: data_in, data_in_valid, data_in_finished, slave_id and rnw.
- Lets internal logic (BIST, boot loader, DMA) read and write any SCARF slave, for example external SRAM, without SPI.
- Accepts one command at a time. Emits the 3 address bytes and then the data bytes, spaced by a programmable gap. Streams write data in and read data out.

Parameters:
- BYTE_GAP, 4: idle clocks between consecutive data_in_valid pulses. Minimum 2. Gives slaves the access time an SPI byte would.
- IDLE_SLAVE_ID, 7'h00: slave_id driven when no transaction is active. This ID is reserved.

Ports:
- clk  in  1  system clock
- rst_n_sync  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_slave_id  in  7  target slave
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  19  start address
- cmd_len  in  16  number of data bytes; 0 is legal (address only)
- wr_data  in  8  write byte
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed this cycle
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse per read byte; no backpressure
- busy  out  1  transaction active
- done  out  1  one-cycle pulse when a transaction ends
- nack  out  1  sticky ID mismatch; cleared on next command accept
- read_data_out  in  8  OR/mux of slave read buses
- data_in  out  8  byte to slaves
- data_in_valid  out  1  byte strobe
- data_in_finished  out  1  end-of-transaction strobe
- slave_id  out  7  addressed slave
- rnw  out  1  direction to slaves

Behaviour:
- Reset values: data_in=0, data_in_valid=0, data_in_finished=0, slave_id=IDLE_SLAVE_ID, rnw=0, rd_data=0, rd_valid=0, wr_ready=0, busy=0, done=0, nack=0, cmd_ready=1. Reset mid-transaction aborts immediately; no finished pulse is issued.
- FSM states: IDLE, GAP, ADDR, DATA, FINISH.
- IDLE:
  - cmd_valid with cmd_ready captures the command, sets slave_id and rnw, clears nack, sets busy, resets the byte index to 0, and goes to GAP.
  - slave_id and rnw stay stable until the FINISH cycle.
- GAP: gap counter counts BYTE_GAP clocks, then goes to ADDR (byte index < 3) or DATA.
- ADDR:
  - One-cycle data_in_valid with data_in = {5'b0,addr[18:16]}, then addr[15:8], then addr[7:0]. Returns to GAP after each.
  - On the first address pulse, sample read_data_out. If it differs from {1'b0,slave_id}, set nack and go to FINISH after this byte.
  - After byte 3: go to FINISH if cmd_len==0, else GAP.
- DATA, write:
  - data_in_valid is asserted only when wr_valid=1; wr_ready=1 in that same cycle, and data_in=wr_data.
  - If wr_valid=0 at the end of the gap, stall in DATA with data_in_valid low until it arrives. No timeout.
- DATA, read:
  - data_in_valid pulses with data_in=8'h00.
  - In the same cycle, rd_data<=read_data_out and rd_valid pulses next cycle (1-cycle latency from strobe).
  - The strobe increments the slave address, so each sample reflects the pre-increment address.
- Remaining count:
  - Decrements on every data strobe; when it reaches 0, go to FINISH after the gap.
  - The count is 16 bits. cmd_len=16'hFFFF issues 65535 bytes.
  - Slave address saturation is slave-defined; the master does not wrap or check it.
- FINISH:
  - Waits BYTE_GAP clocks, then pulses data_in_finished for 1 cycle.
  - The next cycle: slave_id=IDLE_SLAVE_ID, rnw=0, busy=0, done=1 for 1 cycle, back to IDLE.
- cmd_valid while busy is ignored (cmd_ready=0).
- data_in_valid and data_in_finished are never high in the same cycle.
- Consecutive strobes are never closer than BYTE_GAP+1 clocks.

Test Plan:
- Write, slave 7'h02, addr 19'h12345, len 3, data A1 B2 C3 always valid -> data_in sequence 01 23 45 A1 B2 C3, strobes spaced 5 clocks, then finished, then done; external SRAM model holds A1/B2/C3 at 12345..12347; nack=0.
- Read, slave 7'h02, addr 19'h00010, len 4, SRAM preloaded 10 11 12 13 -> rd_valid x4 with rd_data 10 11 12 13; data_in=00 in data phase; rnw=1 throughout.
- Wrong ID: slave_id 7'h05 with no such slave (read_data_out=0) -> nack=1, only the first address byte emitted, finished+done still issued; next accepted command clears nack.
- Write stall: wr_valid low for 20 clocks before the 2nd data byte -> data_in_valid held low, no extra strobes, transaction completes with correct data.
- cmd_len=0 -> exactly 3 address strobes then finished; cmd_valid during busy ignored.
- Reset asserted mid-DATA of a read -> all outputs at reset values immediately; a new command after reset completes normally.
